// File: rtl/bounce_box_gen.sv
// Bouncing box pattern generator for the VGA output stage.
// Box position steps once per frame at the start of vertical blanking, so the visible image never tears.
module bounce_box_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned BOX_SIZE  = 32,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned INIT_X    = 0,
  parameter int unsigned INIT_Y    = 0,
  parameter logic [7:0]  BOX_COLOR = 8'hE0,
  parameter logic [7:0]  BG_COLOR  = 8'h03
) (
  input  logic       vgaclk,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       pause,
  output logic [2:0] out_red,
  output logic [2:0] out_green,
  output logic [1:0] out_blue,
  output logic       frame_tick,
  output logic [7:0] bounce_count
);

  localparam logic [10:0] XMax = 11'(H_VISIBLE - BOX_SIZE);
  localparam logic [10:0] YMax = 11'(V_VISIBLE - BOX_SIZE);
  localparam logic [10:0] Spd  = 11'(SPEED);
  localparam logic [10:0] Box  = 11'(BOX_SIZE);

  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [7:0]  bounce_q;
  logic        tick_q;
  logic        update, bounce_x, bounce_y;
  logic [10:0] x_ext, y_ext, x_inc, x_dec, y_inc, y_dec;
  logic [10:0] hc_ext, vc_ext;
  logic [7:0]  color;

  assign update = (hc == 10'd0) && (vc == 10'(V_VISIBLE));
  // 11-bit arithmetic keeps the edge comparisons free of wrap-around
  assign x_ext  = {1'b0, box_x_q};
  assign y_ext  = {1'b0, box_y_q};
  assign x_inc  = x_ext + Spd;
  assign x_dec  = x_ext - Spd;
  assign y_inc  = y_ext + Spd;
  assign y_dec  = y_ext - Spd;

  always_comb begin
    box_x_d  = x_inc[9:0];
    dir_x_d  = dir_x_q;
    bounce_x = 1'b0;
    if (dir_x_q) begin
      if (x_inc >= XMax) begin
        box_x_d  = XMax[9:0];
        dir_x_d  = 1'b0;
        bounce_x = 1'b1;
      end
    end else if (x_ext <= Spd) begin
      box_x_d  = 10'd0;
      dir_x_d  = 1'b1;
      bounce_x = 1'b1;
    end else begin
      box_x_d  = x_dec[9:0];
    end
  end

  always_comb begin
    box_y_d  = y_inc[9:0];
    dir_y_d  = dir_y_q;
    bounce_y = 1'b0;
    if (dir_y_q) begin
      if (y_inc >= YMax) begin
        box_y_d  = YMax[9:0];
        dir_y_d  = 1'b0;
        bounce_y = 1'b1;
      end
    end else if (y_ext <= Spd) begin
      box_y_d  = 10'd0;
      dir_y_d  = 1'b1;
      bounce_y = 1'b1;
    end else begin
      box_y_d  = y_dec[9:0];
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      box_x_q  <= 10'(INIT_X);
      box_y_q  <= 10'(INIT_Y);
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      bounce_q <= 8'd0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= update;
      if (update && !pause) begin
        box_x_q <= box_x_d;
        box_y_q <= box_y_d;
        dir_x_q <= dir_x_d;
        dir_y_q <= dir_y_d;
        if (bounce_x || bounce_y) begin
          bounce_q <= bounce_q + 8'd1;
        end
      end
    end
  end

  assign hc_ext = {1'b0, hc};
  assign vc_ext = {1'b0, vc};

  always_comb begin
    color = BG_COLOR;
    if (hc >= 10'(H_VISIBLE) || vc >= 10'(V_VISIBLE)) begin
      color = 8'h00;
    end else if (hc >= box_x_q && hc_ext < x_ext + Box &&
                 vc >= box_y_q && vc_ext < y_ext + Box) begin
      color = BOX_COLOR;
    end
  end

  assign out_red      = color[7:5];
  assign out_green    = color[4:2];
  assign out_blue     = color[1:0];
  assign frame_tick   = tick_q;
  assign bounce_count = bounce_q;

endmodule

// File: doc/bounce_box_gen.md
Name: bounce_box_gen

Overview:
Graphics source that feeds the VGA timing/output stage. It takes that stage's horizontal/vertical counters and returns the 8-bit colour for the current pixel. It draws a square box on a solid background. Once per frame, during vertical blanking, the box moves diagonally and bounces off the screen edges, so motion never tears mid-frame.

Parameters:
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
BOX_SIZE, 32, box edge length in pixels
SPEED, 2, pixels moved per axis per frame (must be >=1 and < BOX_SIZE)
INIT_X, 0, box left column after reset (must be <= H_VISIBLE-BOX_SIZE)
INIT_Y, 0, box top line after reset (must be <= V_VISIBLE-BOX_SIZE)
BOX_COLOR, 8'hE0, packed {r[2:0],g[2:0],b[1:0]} box colour
BG_COLOR, 8'h03, packed background colour

Ports:
vgaclk  input  1  25 MHz pixel clock
rst  input  1  synchronous, active-high reset
hc  input  10  horizontal counter from VGA stage (0..799)
vc  input  10  vertical counter from VGA stage (0..524)
pause  input  1  when high at the update point, motion is frozen for that frame
out_red  output  3  red for current pixel
out_green  output  3  green for current pixel
out_blue  output  2  blue for current pixel
frame_tick  output  1  one-cycle pulse after each update point
bounce_count  output  8  number of frames in which a bounce occurred, mod 256

Behaviour:
- One clock (vgaclk); reset is synchronous and active-high (rst). All state updates occur on the vgaclk rising edge.
- State registers: box_x[9:0], box_y[9:0], dir_x, dir_y (1 = increasing), bounce_count[7:0], frame_tick.
- Reset values:
  - box_x = INIT_X, box_y = INIT_Y
  - dir_x = dir_y = 1
  - bounce_count = 0, frame_tick = 0
  - rst has priority over everything, including an update in the same cycle.
- Update point: the edge on which hc == 0 && vc == V_VISIBLE. This occurs exactly once per frame.
  - frame_tick is registered: it is high for exactly the one cycle following that edge, otherwise 0.
  - frame_tick pulses whether or not pause is asserted.
- Motion at the update point, only when pause == 0. Each axis is evaluated independently; X is shown, Y is identical using V_VISIBLE.
  - dir_x = 1:
    - if box_x + SPEED >= H_VISIBLE - BOX_SIZE: box_x <= H_VISIBLE - BOX_SIZE, dir_x <= 0 (bounce)
    - else box_x <= box_x + SPEED
  - dir_x = 0:
    - if box_x <= SPEED: box_x <= 0, dir_x <= 1 (bounce)
    - else box_x <= box_x - SPEED
  - Compare in 11 bits so there is no overflow.
- bounce_count: +1 (wrapping 255 -> 0) at an update where either axis bounces. A corner hit, where both axes bounce, counts once.
- pause is sampled only at the update point. Toggling it mid-frame has no effect.
- Pixel output is combinational from hc, vc and the registered state, with zero latency. This matches the VGA stage, which uses colour in the same cycle as its counters.
  - Blanking: if hc >= H_VISIBLE or vc >= V_VISIBLE, outputs are all 0.
  - Box: else if box_x <= hc < box_x+BOX_SIZE and box_y <= vc < box_y+BOX_SIZE, output BOX_COLOR.
  - Otherwise output BG_COLOR.
  - Unpack each colour as red = [7:5], green = [4:2], blue = [1:0].
- Because updates happen only at vc == V_VISIBLE, box position is constant for the entire visible region of every frame.
- Reset mid-frame: state returns to reset values on the next edge. Output immediately reflects INIT_X/INIT_Y. No update occurs until the next update point after rst deasserts.

Test Plan:
- Defaults; reset, then run to the first update -> box_x=2, box_y=2; frame_tick high exactly 1 cycle after the (hc=0, vc=480) edge. At hc=2,vc=2 outputs are 111/000/00. At hc=1,vc=2 outputs are 000/000/11.
- INIT_X=604, INIT_Y=100; three updates -> box_x 606, 608 (dir_x flips, bounce_count=1), then 606; box_y 102, 104, 106.
- Corner: INIT_X=606, INIT_Y=446; one update -> box_x=608, box_y=448, both dirs 0, bounce_count=1 (not 2). Next update -> 606, 446.
- pause=1 held across an update point -> box_x/box_y/dirs unchanged and frame_tick still pulses. pause=1 only during vc=100..200 -> normal movement.
- Assert rst for 1 cycle at vc=200 after several frames -> box_x=INIT_X, box_y=INIT_Y, dirs=1, bounce_count=0, frame_tick=0. Position unchanged until vc=480.
- Boundaries with box at (100,100): hc=131,vc=131 gives box colour; hc=132 or vc=132 gives background; hc=640,vc=0 and hc=0,vc=480 give all-zero outputs.
